// File: rtl/riscv_pkg.sv
// riscv_pkg: constants and types shared by the fetch stage
package riscv_pkg;
    localparam int FETCH_XLEN = 64;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    localparam logic [3:0] CAUSE_INSTR_MISALIGNED = 4'd0;
    localparam logic [3:0] CAUSE_INSTR_ACCESS_FAULT = 4'd1;
    typedef struct packed {
        logic [31:0] instr;
        logic [FETCH_XLEN-1:0] pc;
        logic err;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small power-of-two FIFO with synchronous clear and occupancy count
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic clear,
    input  logic push,
    input  logic pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    assign dout = mem[rd_ptr];
    // pointers and occupancy; clear wins over push/pop
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
            count <= count + CW'(push) - CW'(pop);
        end
    end
    // storage write, no reset needed since count gates visibility
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/ifetch.sv
// ifetch: instruction fetch stage feeding idecode from a valid/ready instruction memory
module ifetch
    import riscv_pkg::*;
#(
    parameter int XLEN = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h1000,
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic stall,
    input  logic redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic imem_req_valid,
    input  logic imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic imem_resp_err,
    output logic [31:0] instr,
    output logic [XLEN-1:0] pc,
    output logic instr_valid,
    output logic fetch_fault,
    output logic [3:0] fault_cause
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);
    logic [XLEN-1:0] fetch_pc, tag_pc;
    logic [CW-1:0] drop_cnt, tag_count, q_count, in_flight;
    logic [CW:0] used;
    logic halted, mis_pend;
    logic hs, resp, accept, load, q_empty, have, q_push, q_pop, clear;
    fetch_entry_t resp_entry, q_head, head;
    // live tags plus stale drops is exactly what memory still owes us
    assign in_flight = tag_count + drop_cnt;
    assign used = {1'b0, in_flight} + {1'b0, q_count};
    assign imem_req_valid = !reset && !halted && used < DEPTH_V;
    assign imem_req_addr = fetch_pc;
    assign hs = imem_req_valid && imem_req_ready;
    assign resp = !reset && imem_resp_valid;
    assign accept = resp && drop_cnt == '0 && !redirect;
    assign load = !stall || !instr_valid;
    assign q_empty = q_count == '0;
    assign resp_entry = '{instr: imem_resp_data, pc: tag_pc, err: imem_resp_err};
    assign head = q_empty ? resp_entry : q_head;
    assign have = !q_empty || accept;
    assign q_push = accept && !(load && q_empty);
    assign q_pop = load && !q_empty;
    assign clear = reset || redirect;
    fetch_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN)) u_tags (
        .clk(clk), .clear(clear), .push(hs && !redirect), .pop(accept),
        .din(fetch_pc), .dout(tag_pc), .count(tag_count)
    );
    fetch_fifo #(.DEPTH(DEPTH), .WIDTH($bits(fetch_entry_t))) u_queue (
        .clk(clk), .clear(clear), .push(q_push), .pop(q_pop),
        .din(resp_entry), .dout(q_head), .count(q_count)
    );
    // fetch PC, stale-response drop counter and halt state
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            drop_cnt <= '0;
            halted <= 1'b0;
            mis_pend <= 1'b0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            drop_cnt <= in_flight + CW'(hs) - CW'(resp);
            halted <= redirect_pc[1:0] != 2'b00;
            mis_pend <= redirect_pc[1:0] != 2'b00;
        end else begin
            fetch_pc <= hs ? fetch_pc + XLEN'(4) : fetch_pc;
            drop_cnt <= (resp && drop_cnt != '0) ? drop_cnt - CW'(1) : drop_cnt;
            halted <= halted || (accept && imem_resp_err);
        end
    end
    // decode-facing output register; a pending misaligned target is reported once the queue is empty
    always_ff @(posedge clk) begin
        if (reset) begin
            instr <= NOP_INSTR;
            pc <= RESET_PC;
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
            fault_cause <= CAUSE_INSTR_MISALIGNED;
        end else if (redirect) begin
            instr <= NOP_INSTR;
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
        end else if (load) begin
            instr <= (have && !head.err) ? head.instr : NOP_INSTR;
            pc <= have ? head.pc : mis_pend ? fetch_pc : pc;
            instr_valid <= have || mis_pend;
            fetch_fault <= have ? head.err : mis_pend;
            fault_cause <= (have && head.err) ? CAUSE_INSTR_ACCESS_FAULT : CAUSE_INSTR_MISALIGNED;
        end
    end
endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed self-checking bench for ifetch with an in-order memory model
module tb_ifetch;
    logic clk, reset, stall, redirect;
    logic [63:0] redirect_pc;
    logic imem_req_valid, imem_req_ready;
    logic [63:0] imem_req_addr;
    logic imem_resp_valid, imem_resp_err;
    logic [31:0] imem_resp_data;
    logic [31:0] instr;
    logic [63:0] pc;
    logic instr_valid, fetch_fault;
    logic [3:0] fault_cause;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 1;
    logic [63:0] err_addr = '1;
    logic [63:0] addr_q[$];
    int due_q[$];
    logic [127:0] got, exp;

    ifetch dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data), .imem_resp_err(imem_resp_err),
        .instr(instr), .pc(pc), .instr_valid(instr_valid), .fetch_fault(fetch_fault), .fault_cause(fault_cause)
    );

    function automatic logic [31:0] dat(logic [63:0] a);
        return 32'hC0DE0000 ^ a[31:0];
    endfunction

    initial clk = 1'b0;
    // free-running clock
    always #5 clk = ~clk;

    // memory: record accepted requests with their due cycle; shares the reset
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            addr_q.delete();
            due_q.delete();
        end else if (imem_req_valid && imem_req_ready) begin
            addr_q.push_back(imem_req_addr);
            due_q.push_back(cyc + lat);
        end
    end

    // memory: return responses in order once due
    always @(negedge clk) begin
        if (addr_q.size() > 0 && due_q[0] <= cyc) begin
            imem_resp_valid <= 1'b1;
            imem_resp_data <= dat(addr_q[0]);
            imem_resp_err <= addr_q[0] == err_addr;
            addr_q.pop_front();
            due_q.pop_front();
        end else begin
            imem_resp_valid <= 1'b0;
            imem_resp_data <= 32'h0;
            imem_resp_err <= 1'b0;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic restart(input int l, input logic [63:0] e);
        reset = 1'b1;
        lat = l;
        err_addr = e;
        step(2);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        lat = 1;
        err_addr = '1;
        step(1);
        redirect = 1'b1;
        redirect_pc = 64'h5000;
        step(1);
        redirect = 1'b0;
        step(1);
        got = {imem_req_valid, instr_valid, fetch_fault, fault_cause, pc, instr};
        exp = {1'b0, 1'b0, 1'b0, 4'd0, 64'h1000, 32'h00000013};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_state: got %h expected %h", got, exp); end
        reset = 1'b0;
        #1;
        got = {imem_req_valid, imem_req_addr};
        exp = {1'b1, 64'h1000};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_first_req: got %h expected %h", got, exp); end
        step(1);
        got = {imem_req_valid, imem_req_addr, instr_valid};
        exp = {1'b1, 64'h1004, 1'b0};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_second_req: got %h expected %h", got, exp); end
        step(1);
        got = {instr_valid, pc, instr, imem_req_addr};
        exp = {1'b1, 64'h1000, dat(64'h1000), 64'h1008};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_first_instr: got %h expected %h", got, exp); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            got = {instr_valid, pc, instr, (i == 0) | imem_req_valid};
            exp = {1'b1, 64'h1000, dat(64'h1000), i == 0};
            checks++;
            if (got !== exp) begin errors++; $display("FAIL stall_hold_%0d: got %h expected %h", i, got, exp); end
            step(1);
        end
        stall = 1'b0;
        got = {instr_valid, pc, imem_req_valid};
        exp = {1'b1, 64'h1000, 1'b0};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL stall_release: got %h expected %h", got, exp); end
        for (int i = 1; i <= 3; i++) begin
            step(1);
            got = {instr_valid, fetch_fault, pc, instr};
            exp = {1'b1, 1'b0, 64'h1000 + 64'(4 * i), dat(64'h1000 + 64'(4 * i))};
            checks++;
            if (got !== exp) begin errors++; $display("FAIL stall_resume_%0d: got %h expected %h", i, got, exp); end
        end
    endtask

    task automatic test_redirect();
        restart(3, '1);
        step(2);
        got = {imem_req_valid};
        exp = {1'b0};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL redir_two_outstanding: got %h expected %h", got, exp); end
        redirect = 1'b1;
        redirect_pc = 64'h2000;
        step(1);
        redirect = 1'b0;
        for (int i = 0; i < 5; i++) begin
            got = {instr_valid};
            exp = {1'b0};
            checks++;
            if (got !== exp) begin errors++; $display("FAIL redir_drop_%0d: got %h expected %h", i, got, exp); end
            step(1);
        end
        got = {instr_valid, fetch_fault, pc, instr};
        exp = {1'b1, 1'b0, 64'h2000, dat(64'h2000)};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL redir_target: got %h expected %h", got, exp); end
    endtask

    task automatic test_misaligned();
        redirect = 1'b1;
        redirect_pc = 64'h2002;
        step(1);
        redirect = 1'b0;
        got = {instr_valid, imem_req_valid};
        exp = {1'b0, 1'b0};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL mis_first: got %h expected %h", got, exp); end
        for (int i = 0; i < 4; i++) begin
            step(1);
            got = {imem_req_valid, instr_valid, fetch_fault, fault_cause, pc, instr};
            exp = {1'b0, 1'b1, 1'b1, 4'd0, 64'h2002, 32'h00000013};
            checks++;
            if (got !== exp) begin errors++; $display("FAIL mis_fault_%0d: got %h expected %h", i, got, exp); end
        end
        lat = 1;
        redirect = 1'b1;
        redirect_pc = 64'h3000;
        step(1);
        redirect = 1'b0;
        got = {imem_req_valid, imem_req_addr, instr_valid};
        exp = {1'b1, 64'h3000, 1'b0};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL mis_resume_req: got %h expected %h", got, exp); end
        step(2);
        got = {instr_valid, fetch_fault, pc, instr};
        exp = {1'b1, 1'b0, 64'h3000, dat(64'h3000)};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL mis_resume_instr: got %h expected %h", got, exp); end
    endtask

    task automatic test_access_fault();
        restart(1, 64'h1004);
        step(2);
        got = {instr_valid, fetch_fault, pc, instr};
        exp = {1'b1, 1'b0, 64'h1000, dat(64'h1000)};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL fault_prev_ok: got %h expected %h", got, exp); end
        step(1);
        got = {imem_req_valid, instr_valid, fetch_fault, fault_cause, pc, instr};
        exp = {1'b0, 1'b1, 1'b1, 4'd1, 64'h1004, 32'h00000013};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL fault_entry: got %h expected %h", got, exp); end
        for (int i = 0; i < 4; i++) begin
            step(1);
            got = {imem_req_valid};
            exp = {1'b0};
            checks++;
            if (got !== exp) begin errors++; $display("FAIL fault_no_req_%0d: got %h expected %h", i, got, exp); end
        end
    endtask

    task automatic test_back_to_back();
        restart(1, '1);
        step(3);
        redirect = 1'b1;
        redirect_pc = 64'h4000;
        step(1);
        redirect = 1'b0;
        got = {instr_valid, imem_req_valid, imem_req_addr};
        exp = {1'b0, 1'b1, 64'h4000};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL simul_r1: got %h expected %h", got, exp); end
        step(1);
        got = {instr_valid};
        exp = {1'b0};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL simul_r2: got %h expected %h", got, exp); end
        step(1);
        got = {instr_valid, pc, instr};
        exp = {1'b1, 64'h4000, dat(64'h4000)};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL simul_target: got %h expected %h", got, exp); end
        step(1);
        got = {instr_valid, pc, instr};
        exp = {1'b1, 64'h4004, dat(64'h4004)};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL simul_next: got %h expected %h", got, exp); end
        reset = 1'b1;
        step(1);
        got = {imem_req_valid, instr_valid, pc, instr};
        exp = {1'b0, 1'b0, 64'h1000, 32'h00000013};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL midreset_state: got %h expected %h", got, exp); end
        reset = 1'b0;
        #1;
        got = {imem_req_valid, imem_req_addr};
        exp = {1'b1, 64'h1000};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL midreset_req: got %h expected %h", got, exp); end
        step(2);
        got = {instr_valid, pc, instr};
        exp = {1'b1, 64'h1000, dat(64'h1000)};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL midreset_instr: got %h expected %h", got, exp); end
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        imem_req_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_stall();
        test_redirect();
        test_misaligned();
        test_access_fault();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ifetch.md
Name: ifetch

Overview:
- Instruction fetch stage. It is the producer side of the decode interface: it drives `instr` and `pc` into idecode.
- Keeps the fetch PC and issues word requests to instruction memory over a valid/ready channel.
- Buffers in-order responses in a small queue.
- Handles redirects from branch, jump and trap logic by discarding stale fetches and restarting at the new PC.

Parameters:
- XLEN, 64: address and PC width.
- RESET_PC, 64'h1000: PC loaded on reset.
- DEPTH, 2: maximum entries outstanding plus buffered. Power of two, at least 2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  decode not accepting; output registers hold
- redirect  in  1  one-cycle pulse: restart fetch at redirect_pc
- redirect_pc  in  XLEN  new fetch target
- imem_req_valid  out  1  request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  word address requested
- imem_resp_valid  in  1  response valid; in order; at least 1 cycle after its handshake; no backpressure
- imem_resp_data  in  32  instruction word
- imem_resp_err  in  1  access fault for this response
- instr  out  32  instruction to decode
- pc  out  XLEN  PC of instr
- instr_valid  out  1  instr/pc valid this cycle
- fetch_fault  out  1  fault in place of instruction
- fault_cause  out  4  0 = instruction address misaligned, 1 = instruction access fault

Behaviour:
- Reset:
  - fetch_pc = RESET_PC; outstanding = 0; drop_cnt = 0; queue empty; halted = 0.
  - Outputs: imem_req_valid = 0, instr = 32'h00000013 (NOP), pc = RESET_PC, instr_valid = 0, fetch_fault = 0, fault_cause = 0.
  - Reset overrides every other input in the same cycle. The memory shares this reset; responses arriving in a reset cycle are ignored.
- Request issue:
  - imem_req_valid = !halted && (outstanding + queue_count) < DEPTH.
  - imem_req_addr = fetch_pc.
  - On handshake, fetch_pc += 4 (wraps modulo 2^XLEN) and the issue PC is pushed into a PC tag FIFO.
  - addr is stable while valid && !ready.
- Response:
  - Accepted only when drop_cnt == 0; the entry {data, pc_tag, err} is pushed into the queue.
  - When drop_cnt != 0, the response is discarded and drop_cnt decrements.
- Output register:
  - Loads the queue head when !stall || !instr_valid.
  - Queue empty in a load cycle: instr_valid = 0, instr = NOP.
  - Latency: a response accepted in cycle N with an empty queue and no stall gives instr_valid = 1 in cycle N+1.
  - While stall && instr_valid, all outputs hold. The queue continues filling up to DEPTH; requests stop when full.
- Redirect (priority over stall):
  - Next cycle: fetch_pc = redirect_pc, queue and tag FIFO cleared, instr_valid = 0, instr = NOP, fetch_fault = 0, halted = 0.
  - drop_cnt = outstanding + (handshake this cycle) - (response this cycle).
  - A request handshaking in the redirect cycle is counted as stale.
- Misaligned redirect (redirect_pc[1:0] != 0):
  - No request is issued; halted = 1.
  - Once the output is free: instr_valid = 1, fetch_fault = 1, fault_cause = 0, pc = redirect_pc, instr = NOP.
  - Holds until the next redirect.
- Access fault (resp_err = 1):
  - The entry reaches the output with fetch_fault = 1, fault_cause = 1, instr = NOP.
  - halted = 1 from acceptance; already-issued responses are still buffered.
- Simultaneous events:
  - Redirect and response in the same cycle: the response is dropped and not counted in drop_cnt.
  - Redirect during reset: ignored.

Decomposition:
- riscv_pkg holds:
  - NOP_INSTR = 32'h00000013.
  - CAUSE_INSTR_MISALIGNED = 4'd0, CAUSE_INSTR_ACCESS_FAULT = 4'd1.
  - fetch_entry_t struct {instr[31:0], pc[XLEN-1:0], err}.
- One sub-module, fetch_fifo: parameterised DEPTH, synchronous clear, push/pop/count. It is instantiated twice: once as the PC tag FIFO and once as the response queue.

Test Plan:
- Reset sequence:
  - Stimulus: reset 3 cycles, then release; memory with ready = 1 and 1-cycle response latency.
  - Required: first req addr = 0x1000, then 0x1004, 0x1008. First instr_valid with pc = 0x1000 in the cycle after the first response.
- Stall:
  - Stimulus: stall = 1 for 4 cycles while instr_valid.
  - Required: instr/pc held. Exactly DEPTH = 2 entries outstanding plus buffered, then imem_req_valid = 0. After release, pcs continue contiguously with none skipped.
- Redirect with two requests outstanding:
  - Stimulus: redirect to 0x2000 while two requests are outstanding.
  - Required: both stale responses are dropped; instr_valid = 0 the next cycle; next valid pc = 0x2000.
- Misaligned redirect:
  - Stimulus: redirect to 0x2002.
  - Required: no request issued; instr_valid = 1, fetch_fault = 1, fault_cause = 0, pc = 0x2002. After a redirect to 0x3000, fetch resumes normally.
- Access fault:
  - Stimulus: resp_err = 1 on the response for 0x1004.
  - Required: 0x1000 delivered normally, then a fault entry with pc = 0x1004, fault_cause = 1, instr = 0x00000013; no further requests.
- Simultaneous redirect and response, and reset mid-fetch:
  - Stimulus: redirect in the same cycle as a response; separately, reset asserted with requests outstanding.
  - Required: the same-cycle response is never delivered and drop_cnt reaches 0 correctly. The reset case restarts at 0x1000 with instr_valid = 0.
